// File: rtl/l1_epoch_sequencer.sv
// l1_epoch_sequencer: replays ROM samples into the L1 layer with decay gaps,
// attention pulses on silent samples and end-of-epochs. Option: L1_SEQ_STATS_EN.
module l1_epoch_sequencer #(
   parameter int p_s       = 25,
   parameter int p_n       = 10,
   parameter int p_frames  = 16,
   parameter int p_samples = 100,
   parameter int p_epochs  = 8,
   parameter int p_gap     = 'h3f,
   parameter int p_aw      = 11
) (
`ifdef L1_SEQ_STATS_EN
   output logic [15:0]     o_miss_cnt,
   output logic [15:0]     o_miss_last,
`endif
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic [p_aw-1:0] o_mem_addr,
   output logic            o_mem_rd,
   input  logic [p_s-1:0]  i_mem_data,
   input  logic [p_n-1:0]  i_spike,
   output logic [p_s-1:0]  o_event,
   output logic            o_gas,
   output logic            o_endof_epochs,
   output logic            o_busy,
   output logic [7:0]      o_epoch
);

   localparam int FW = (p_frames > 1) ? $clog2(p_frames) : 1;
   localparam int SW = (p_samples > 1) ? $clog2(p_samples) : 1;
   localparam int EW = (p_epochs > 1) ? $clog2(p_epochs) : 1;
   localparam int GW = $clog2(p_gap + 1);

   localparam logic [FW-1:0] F_LAST = FW'(p_frames - 1);
   localparam logic [SW-1:0] S_LAST = SW'(p_samples - 1);
   localparam logic [EW-1:0] E_LAST = EW'(p_epochs - 1);
   localparam logic [GW-1:0] G_LAST = GW'(p_gap - 1);

   typedef enum logic [2:0] {
      IDLE, PRESENT, DRAIN, GAP, NEXT, DONE
   } state_t;

   state_t        state;
   logic [FW-1:0] frame;
   logic [SW-1:0] sample;
   logic [EW-1:0] ep;
   logic [GW-1:0] gap;
   logic          drain;
   logic          rd_q;
   logic          hit;
   logic          any_spike;
   logic          start_ok;

   assign any_spike = |i_spike;
   assign start_ok  = i_start && (state == IDLE || state == DONE);

   // sequencing FSM, ROM addressing, frame pipeline and attention pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         frame          <= '0;
         sample         <= '0;
         ep             <= '0;
         gap            <= '0;
         drain          <= 1'b0;
         rd_q           <= 1'b0;
         hit            <= 1'b0;
         o_mem_addr     <= '0;
         o_mem_rd       <= 1'b0;
         o_event        <= '0;
         o_gas          <= 1'b0;
         o_endof_epochs <= 1'b0;
         o_busy         <= 1'b0;
         o_epoch        <= '0;
      end else begin
         rd_q    <= o_mem_rd;
         o_event <= rd_q ? i_mem_data : '0;
         o_gas   <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state          <= PRESENT;
                  frame          <= '0;
                  sample         <= '0;
                  ep             <= '0;
                  hit            <= 1'b0;
                  o_mem_addr     <= '0;
                  o_mem_rd       <= 1'b1;
                  o_endof_epochs <= 1'b0;
                  o_busy         <= 1'b1;
                  o_epoch        <= '0;
               end
            end
            PRESENT: begin
               if (any_spike) hit <= 1'b1;
               if (frame == F_LAST) begin
                  state    <= DRAIN;
                  o_mem_rd <= 1'b0;
                  drain    <= 1'b0;
               end else begin
                  frame      <= frame + FW'(1);
                  o_mem_addr <= o_mem_addr + p_aw'(1);
               end
            end
            DRAIN: begin
               if (any_spike) hit <= 1'b1;
               if (drain) begin
                  state <= GAP;
                  gap   <= '0;
               end else begin
                  drain <= 1'b1;
               end
            end
            GAP: begin
               if (any_spike) hit <= 1'b1;
               if (gap == G_LAST) begin
                  state <= NEXT;
                  o_gas <= ~(hit | any_spike);
               end else begin
                  gap <= gap + GW'(1);
               end
            end
            NEXT: begin
               // a spike seen here is credited to the sample that follows
               hit   <= any_spike;
               frame <= '0;
               if (sample == S_LAST) begin
                  sample <= '0;
                  if (ep == E_LAST) begin
                     state          <= DONE;
                     o_busy         <= 1'b0;
                     o_endof_epochs <= 1'b1;
                  end else begin
                     state      <= PRESENT;
                     ep         <= ep + EW'(1);
                     o_epoch    <= (o_epoch == 8'hff) ? o_epoch : o_epoch + 8'd1;
                     o_mem_addr <= '0;
                     o_mem_rd   <= 1'b1;
                  end
               end else begin
                  state      <= PRESENT;
                  sample     <= sample + SW'(1);
                  o_mem_addr <= o_mem_addr + p_aw'(1);
                  o_mem_rd   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef L1_SEQ_STATS_EN
   logic [15:0] miss_sum;

   assign miss_sum = (o_miss_cnt == 16'hffff) ? o_miss_cnt
                                              : o_miss_cnt + 16'(o_gas);

   // per-epoch count of attention pulses, latched at each epoch wrap
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_miss_cnt  <= '0;
         o_miss_last <= '0;
      end else if (start_ok) begin
         o_miss_cnt <= '0;
      end else if (state == NEXT) begin
         if (sample == S_LAST) begin
            o_miss_last <= miss_sum;
            o_miss_cnt  <= '0;
         end else begin
            o_miss_cnt <= miss_sum;
         end
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule
